l1d_cache: RTL



---
 rtl/l1d_cache.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/l1d_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one-word lines.
// Uses the same stb/we/sel/stall/ack handshake upstream (hart) and downstream (block_ram).
module l1d_cache #(
    parameter int XLEN  = 32,
    parameter int LINES = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [2:0]      i_wb_sel,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_wb_ack,
    output logic            o_wb_stall,
    output logic            o_wb_err,
    output logic            o_mem_stb,
    output logic            o_mem_we,
    output logic [2:0]      o_mem_sel,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_data,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic            i_mem_stall,
    input  logic            i_mem_ack
);
    localparam int IDX = $clog2(LINES);
    localparam int TW  = XLEN - 2 - IDX;

    typedef enum logic [2:0] {S_IDLE, S_FILL_REQ, S_FILL_WAIT, S_WR_REQ, S_WR_WAIT} state_t;
    state_t r_state, w_next;

    logic [LINES-1:0] r_valid;
    logic [TW-1:0]    r_tag  [LINES];
    logic [XLEN-1:0]  r_line [LINES];

    logic [XLEN-1:0]  r_addr, r_data, r_wb_data;
    logic [2:0]       r_sel;
    logic             r_hit, r_ack, r_err;

    logic [IDX-1:0]   w_idx, w_cidx;
    logic [TW-1:0]    w_tag;
    logic             w_hit, w_misal, w_accept;

    assign w_idx    = i_addr[2 +: IDX];
    assign w_tag    = i_addr[XLEN-1:2+IDX];
    assign w_cidx   = r_addr[2 +: IDX];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_misal  = ((i_wb_sel[1:0] == 2'b01) && i_addr[0]) ||
                      (i_wb_sel[1] && (i_addr[1:0] != 2'b00));
    assign w_accept = i_wb_stb && (r_state == S_IDLE);

    // Pick the addressed byte/half out of a word and sign- or zero-extend it.
    function automatic logic [XLEN-1:0] f_extract(input logic [XLEN-1:0] word,
                                                  input logic [1:0] off, input logic [2:0] sel);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (sel[1:0])
            2'b00:   f_extract = sel[2] ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
            2'b01:   f_extract = sel[2] ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            default: f_extract = word;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] f_merge(input logic [XLEN-1:0] old, input logic [XLEN-1:0] wd,
                                                input logic [1:0] off, input logic [2:0] sel);
        logic [XLEN-1:0] mask, val;
        case (sel[1:0])
            2'b00: begin
                mask = XLEN'(8'hFF) << {off, 3'b000};
                val  = XLEN'(wd[7:0]) << {off, 3'b000};
            end
            2'b01: begin
                mask = XLEN'(16'hFFFF) << {off[1], 4'b0000};
                val  = XLEN'(wd[15:0]) << {off[1], 4'b0000};
            end
            default: begin
                mask = '1;
                val  = wd;
            end
        endcase
        f_merge = (old & ~mask) | (val & mask);
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_misal) begin
                    if (i_wb_we)     w_next = S_WR_REQ;
                    else if (!w_hit) w_next = S_FILL_REQ;
                end
            end
            S_FILL_REQ:  if (!i_mem_stall) w_next = S_FILL_WAIT;
            S_FILL_WAIT: if (i_mem_ack)    w_next = S_IDLE;
            S_WR_REQ:    if (!i_mem_stall) w_next = S_WR_WAIT;
            S_WR_WAIT:   if (i_mem_ack)    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid   <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_wb_data <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_sel     <= '0;
            r_hit     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_addr <= i_addr;
                    r_data <= i_data;
                    r_sel  <= i_wb_sel;
                    r_hit  <= w_hit;
                    if (w_misal) r_err <= 1'b1;
                    else if (!i_wb_we && w_hit) begin
                        r_ack     <= 1'b1;
                        r_wb_data <= f_extract(r_line[w_idx], i_addr[1:0], i_wb_sel);
                    end
                end
                S_FILL_WAIT: if (i_mem_ack) begin
                    r_valid[w_cidx] <= 1'b1;
                    r_ack           <= 1'b1;
                    r_wb_data       <= f_extract(i_mem_data, r_addr[1:0], r_sel);
                end
                S_WR_WAIT: if (i_mem_ack) begin
                    r_ack     <= 1'b1;
                    r_wb_data <= '0;
                end
                default: ;
            endcase
        end
    end

    // Line payload needs no reset: it is never read while its valid bit is clear.
    always_ff @(posedge i_clk) begin
        if (r_state == S_FILL_WAIT && i_mem_ack) begin
            r_line[w_cidx] <= i_mem_data;
            r_tag[w_cidx]  <= r_addr[XLEN-1:2+IDX];
        end else if (r_state == S_WR_WAIT && i_mem_ack && r_hit) begin
            r_line[w_cidx] <= f_merge(r_line[w_cidx], r_data, r_addr[1:0], r_sel);
        end
    end

    assign o_wb_stall = (r_state != S_IDLE);
    assign o_wb_ack   = r_ack;
    assign o_wb_err   = r_err;
    assign o_wb_data  = r_wb_data;
    assign o_mem_stb  = (r_state == S_FILL_REQ) || (r_state == S_WR_REQ);
    assign o_mem_we   = (r_state == S_WR_REQ);
    assign o_mem_sel  = o_mem_we ? r_sel : 3'b010;
    assign o_mem_addr = o_mem_we ? r_addr : {r_addr[XLEN-1:2], 2'b00};
    assign o_mem_data = r_data;
endmodule
